oam_dma: RTL and testbench
==========================

// Module: oam_dma
//
// PURPOSE
// - OAM DMA engine: the bus initiator on the OAM write path. A CPU write to FF46
//   copies 160 bytes from {src,8'h00} into sprite attribute memory at FE00-FE9F.
// - Sits beside the PPU on the gameboy clock. Its master port is muxed by the top-level
//   arbiter onto the same address/indata/store bus the PPU register maps decode.
// - dma_busy tells the arbiter to block CPU accesses outside FF80-FFFE.
//
// PARAMETERS
// - REG_ADDR   16'hFF46  CPU-visible DMA source/start register.
// - OAM_BASE   16'hFE00  destination base address.
// - BYTES      160       bytes per transfer; index counter is 8 bits.
//
// PORTS
// - clockgb      in   1   gameboy clock; all state changes on posedge.
// - reset        in   1   asynchronous, active-high reset.
// - address      in   16  CPU bus address.
// - indata       in   8   CPU write data.
// - outdata      out  8   CPU read data; 0 unless the previous cycle was a load of REG_ADDR.
// - load         in   1   CPU read strobe.
// - store        in   1   CPU write strobe.
// - m_address    out  16  master address; 0 when idle.
// - m_indata     in   8   master read data; valid the cycle after m_load (registered-read memory).
// - m_outdata    out  8   master write data.
// - m_load       out  1   master read strobe.
// - m_store      out  1   master write strobe.
// - dma_busy     out  1   transfer in progress.
//
// BEHAVIOUR
// - Reset values:
//   - src=8'h00; state=IDLE; idx=0.
//   - outdata, m_address, m_outdata = 0.
//   - m_load, m_store, dma_busy = 0.
// - Register access:
//   - store && address==REG_ADDR at edge E0: src<=indata.
//   - load && address==REG_ADDR at an edge: outdata<=src on that edge; otherwise outdata<=0.
// - FSM states: IDLE, START, RD, WR.
//   - IDLE -> START on the FF46 store at E0. dma_busy=1 from E0.
//   - START, 1 cycle, no strobes -> RD, idx=0.
//   - RD: m_address={src,idx}, m_load=1 -> WR.
//   - WR: m_address=OAM_BASE+idx, m_outdata=m_indata, m_store=1.
//     - idx==BYTES-1 -> IDLE.
//     - otherwise idx++ and -> RD.
// - Timing:
//   - First RD after E1; last WR after E320; IDLE and dma_busy=0 after E321.
//   - dma_busy is high for exactly 321 cycles.
// - Strobes are registered state outputs. m_load and m_store are never high together.
// - Arithmetic:
//   - Source address is the concatenation {src,idx[7:0]}; it never carries into the high byte.
//   - Destination address is OAM_BASE + {8'h00,idx}. idx never exceeds BYTES-1.
// - Source is used verbatim: no echo-RAM remap and no range check on src.
// - The block ignores its own master writes; the top level never routes m_* back into the CPU port.
// - Simultaneous CPU load and store of REG_ADDR on one edge: the store updates src, and the
//   load returns the old src.
// - Reset mid-transfer: all outputs drop to reset values immediately (asynchronous).
//   No further strobes are issued, and a partial OAM copy remains.
// - FF46 store in the same cycle the last WR completes (E320): the block counts it as a
//   write during busy (see CONFIGURATION).
//
// CONFIGURATION
// - Macro OAM_DMA_RESTART_EN.
// - Defined: an FF46 store while dma_busy updates src and forces state=START, idx=0.
//   The new transfer runs the full 321 cycles from that edge.
// - Undefined: an FF46 store while dma_busy updates src only. The current transfer continues,
//   reading the new src from the next RD onward, and ends at its original time.
//
// STRUCTURE
// - Shared package gb_pkg holds:
//   - constants DMA_REG_ADDR=16'hFF46, OAM_BASE=16'hFE00, OAM_BYTES=160;
//   - enum dma_state_t {IDLE,START,RD,WR}.
// - Single module with register decode inline; no sub-module.
//
// TESTING
// - Reset: assert reset, release -> all outputs 0, dma_busy=0; a FF46 read returns 8'h00 the next cycle.
// - Full copy: source model returns (addr[7:0]^8'h5A); write 8'hC1 to FF46 ->
//   - reads hit C100..C19F in order;
//   - 160 stores go to FE00..FE9F with data i^8'h5A;
//   - dma_busy is high for 321 cycles.
// - Readback: load FF46 during the transfer -> outdata=8'hC1 one cycle later; outdata=0 on the following idle cycle.
// - Mid-transfer rewrite: write 8'hD0 at idx=80.
//   - EN defined: next read is D000 and 321 more busy cycles follow.
//   - EN undefined: next read is D051 and the copy ends at the original E321.
// - Async reset at idx=50 during WR: m_store falls without a clock edge; no stores after reset; FE32..FE9F untouched.
// - Back-to-back: FF46 store on the first idle cycle after busy falls -> new START and a normal 321-cycle transfer.

Source files
------------

// File: rtl/gb_pkg.sv
// Shared gameboy constants and types used by the OAM DMA engine.
package gb_pkg;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam int          OAM_BYTES    = 160;
  localparam logic [7:0]  OAM_LAST     = 8'(OAM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RD    = 2'd2,
    WR    = 2'd3
  } dma_state_t;

  // Destination byte in sprite attribute memory for a given transfer index.
  function automatic logic [15:0] oam_dst(input logic [7:0] idx);
    return OAM_BASE + {8'h00, idx};
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a store to FF46 copies 160 bytes from {src,8'h00} into FE00-FE9F.
// Build macro OAM_DMA_RESTART_EN: a FF46 store while busy restarts the transfer.
module oam_dma
  import gb_pkg::*;
(
  input  logic        clockgb,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  output logic [15:0] m_address,
  input  logic [7:0]  m_indata,
  output logic [7:0]  m_outdata,
  output logic        m_load,
  output logic        m_store,
  output logic        dma_busy
);

  dma_state_t  state_r, state_s;
  logic [7:0]  idx_r, idx_s;
  logic [7:0]  src_r, src_s;
  logic [7:0]  outdata_r;
  logic [15:0] m_address_r, m_address_s;
  logic        m_load_r, m_store_r, dma_busy_r;
  logic        reg_wr_s, reg_rd_s, restart_s;

  assign reg_wr_s = store && (address == DMA_REG_ADDR);
  assign reg_rd_s = load && (address == DMA_REG_ADDR);

`ifdef OAM_DMA_RESTART_EN
  assign restart_s = reg_wr_s && (state_r != IDLE);
`else
  assign restart_s = 1'b0;
`endif

  // Next-state, transfer index and source register update.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    src_s   = src_r;
    if (reg_wr_s) begin
      src_s = indata;
    end else begin
      src_s = src_r;
    end
    if (restart_s) begin
      state_s = START;
      idx_s   = 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (reg_wr_s) begin
            state_s = START;
            idx_s   = 8'd0;
          end else begin
            state_s = IDLE;
          end
        end
        START: begin
          state_s = RD;
          idx_s   = 8'd0;
        end
        RD: state_s = WR;
        WR: begin
          if (idx_r == OAM_LAST) begin
            state_s = IDLE;
          end else begin
            state_s = RD;
            idx_s   = idx_r + 8'd1;
          end
        end
        default: begin
          state_s = IDLE;
          idx_s   = 8'd0;
        end
      endcase
    end
  end

  // Master address for the upcoming cycle; the source high byte never takes a carry.
  always_comb begin
    m_address_s = 16'h0000;
    case (state_s)
      RD:      m_address_s = {src_s, idx_s};
      WR:      m_address_s = oam_dst(idx_s);
      default: m_address_s = 16'h0000;
    endcase
  end

  // State and registered bus outputs, all derived from the next state.
  always_ff @(posedge clockgb or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= 8'd0;
      src_r       <= 8'h00;
      outdata_r   <= 8'h00;
      m_address_r <= 16'h0000;
      m_load_r    <= 1'b0;
      m_store_r   <= 1'b0;
      dma_busy_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      src_r       <= src_s;
      outdata_r   <= reg_rd_s ? src_r : 8'h00;
      m_address_r <= m_address_s;
      m_load_r    <= (state_s == RD);
      m_store_r   <= (state_s == WR);
      dma_busy_r  <= (state_s != IDLE);
    end
  end

  // Read data arrives the cycle after m_load, i.e. during WR, so it is forwarded straight through.
  assign m_outdata = (state_r == WR) ? m_indata : 8'h00;
  assign outdata   = outdata_r;
  assign m_address = m_address_r;
  assign m_load    = m_load_r;
  assign m_store   = m_store_r;
  assign dma_busy  = dma_busy_r;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: source memory / OAM models plus a transfer-level reference.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic [7:0]  indata;
  logic [7:0]  outdata;
  logic        load, store;
  logic [15:0] m_address;
  logic [7:0]  m_indata = 8'h00;
  logic [7:0]  m_outdata;
  logic        m_load, m_store, dma_busy;

  oam_dma dut (
    .clockgb(clk), .reset(reset), .address(address), .indata(indata), .outdata(outdata),
    .load(load), .store(store), .m_address(m_address), .m_indata(m_indata),
    .m_outdata(m_outdata), .m_load(m_load), .m_store(m_store), .dma_busy(dma_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int busy_cnt = 0;
  int overlap  = 0;
  int e_store;
  logic oam_clr = 1'b0;
  logic [7:0] oam [0:159];
  logic [15:0] rd_q[$];
  int          rd_cyc_q[$];
  logic [23:0] wr_q[$];
  int          wr_cyc_q[$];
  logic [15:0] exp_rd[$];
  logic [15:0] exp_wr[$];

  function automatic logic [7:0] src_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h9B;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read source memory and OAM storage.
  always @(posedge clk) begin
    if (m_load) m_indata <= src_fn(m_address);
    if (oam_clr) begin
      for (int k = 0; k < 160; k++) oam[k] <= 8'hEE;
    end else if (m_store && m_address[15:8] == 8'hFE && m_address[7:0] < 8'd160) begin
      oam[m_address[7:0]] <= m_outdata;
    end
  end

  // Bus monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_load) begin rd_q.push_back(m_address); rd_cyc_q.push_back(cyc); end
      if (m_store) begin wr_q.push_back({m_address, m_outdata}); wr_cyc_q.push_back(cyc); end
      if (dma_busy) busy_cnt++;
      if (m_load && m_store) overlap++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_logs();
    rd_q.delete(); rd_cyc_q.delete(); wr_q.delete(); wr_cyc_q.delete();
    exp_rd.delete(); exp_wr.delete();
    busy_cnt = 0;
  endtask

  task automatic do_store(input logic [7:0] v, input logic ld);
    address = 16'hFF46; indata = v; store = 1'b1; load = ld;
    @(posedge clk); #1 e_store = cyc;
    @(negedge clk);
    store = 1'b0; load = 1'b0; address = 16'h0000; indata = 8'h00;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (dma_busy && n < budget);
    chk("idle_timeout", 32'(dma_busy), 32'd0);
  endtask

  task automatic cmp_logs(input int exp_busy);
    chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    chk("n_reads", 32'(rd_q.size()), 32'(exp_rd.size()));
    chk("n_writes", 32'(wr_q.size()), 32'(exp_wr.size()));
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
      chk("rd_addr", 32'(rd_q[i]), 32'(exp_rd[i]));
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
      chk("wr_addr", 32'(wr_q[i][23:8]), 32'(16'hFE00 + {8'h00, exp_wr[i][7:0]}));
      chk("wr_data", 32'(wr_q[i][7:0]), 32'(src_fn(exp_wr[i])));
    end
  endtask

  task automatic check_transfer(input logic [7:0] s, input int e0);
    logic [7:0] b;
    wait_idle(400);
    for (int i = 0; i < 160; i++) begin
      b = 8'(i);
      exp_rd.push_back({s, b});
      exp_wr.push_back({s, b});
    end
    cmp_logs(321);
    if (rd_cyc_q.size() > 0) chk("first_rd_cycle", 32'(rd_cyc_q[0]), 32'(e0 + 1));
    if (wr_cyc_q.size() == 160) chk("last_wr_cycle", 32'(wr_cyc_q[159]), 32'(e0 + 320));
  endtask

  initial begin
    logic [7:0] s, cur_src, s_a, b;
    int e0, n;
    reset = 1'b1; load = 1'b0; store = 1'b0; address = 16'h0000; indata = 8'h00;
    cur_src = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(dma_busy), 32'd0);
    chk("rst_m_load", 32'(m_load), 32'd0);
    chk("rst_m_store", 32'(m_store), 32'd0);
    chk("rst_m_address", 32'(m_address), 32'd0);
    chk("rst_m_outdata", 32'(m_outdata), 32'd0);
    chk("rst_outdata", 32'(outdata), 32'd0);
    load = 1'b1; address = 16'hFF46;
    @(negedge clk);
    chk("rst_readback", 32'(outdata), 32'd0);
    load = 1'b0; address = 16'h0000;
    @(negedge clk);

    // Full copy from C100 with a readback during the transfer.
    clear_logs();
    do_store(8'hC1, 1'b0);
    cur_src = 8'hC1;
    repeat ($urandom_range(3, 250)) @(negedge clk);
    load = 1'b1; address = 16'hFF46;
    @(negedge clk);
    chk("busy_readback", 32'(outdata), 32'hC1);
    load = 1'b0; address = 16'h0000;
    @(negedge clk);
    chk("readback_clears", 32'(outdata), 32'd0);
    check_transfer(8'hC1, e_store);

    // Back-to-back random transfers, each started with a simultaneous FF46 load.
    for (int t = 0; t < 2; t++) begin
      s = 8'($urandom_range(0, 255));
      clear_logs();
      do_store(s, 1'b1);
      chk("ldst_old_src", 32'(outdata), 32'(cur_src));
      cur_src = s;
      check_transfer(s, e_store);
    end

    // Rewrite of the source register while idx 80 is being read.
    s_a = 8'($urandom_range(0, 255));
    clear_logs();
    do_store(s_a, 1'b0);
    e0 = e_store;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (rd_q.size() < 81 && n < 400);
    chk("rewrite_reach", 32'(rd_q.size()), 32'd81);
    do_store(8'hD0, 1'b0);
    cur_src = 8'hD0;
    chk("rewrite_edge", 32'(e_store - e0), 32'd162);
    wait_idle(900);
    for (int i = 0; i < 81; i++) begin
      b = 8'(i);
      exp_rd.push_back({s_a, b});
    end
`ifdef OAM_DMA_RESTART_EN
    for (int i = 0; i < 80; i++) exp_wr.push_back(exp_rd[i]);
    for (int i = 0; i < 160; i++) begin
      b = 8'(i);
      exp_rd.push_back({8'hD0, b});
      exp_wr.push_back({8'hD0, b});
    end
    cmp_logs(162 + 321);
`else
    for (int i = 81; i < 160; i++) begin
      b = 8'(i);
      exp_rd.push_back({8'hD0, b});
    end
    for (int i = 0; i < 160; i++) exp_wr.push_back(exp_rd[i]);
    cmp_logs(321);
`endif

    // Asynchronous reset during the WR of idx 50.
    clear_logs();
    oam_clr = 1'b1;
    @(negedge clk);
    oam_clr = 1'b0;
    do_store(8'hC1, 1'b0);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (wr_q.size() < 51 && n < 400);
    chk("reset_reach", 32'(wr_q.size()), 32'd51);
    chk("pre_reset_store", 32'(m_store), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_m_store", 32'(m_store), 32'd0);
    chk("async_busy", 32'(dma_busy), 32'd0);
    chk("async_m_address", 32'(m_address), 32'd0);
    chk("async_m_outdata", 32'(m_outdata), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_stores_after_reset", 32'(wr_q.size()), 32'd51);
    chk("idle_after_reset", 32'(dma_busy), 32'd0);
    for (int i = 0; i < 160; i++) begin
      b = 8'(i);
      chk("oam_partial", 32'(oam[i]), (i < 50) ? 32'(b ^ 8'h5A) : 32'hEE);
    end
    load = 1'b1; address = 16'hFF46;
    @(negedge clk);
    chk("src_after_reset", 32'(outdata), 32'd0);
    load = 1'b0; address = 16'h0000;
    @(negedge clk);

    chk("ld_st_overlap", 32'(overlap), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
